// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access stage: decoder load/store codes,
// FSM state encoding and the alignment rule.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;

  // Unlisted codes fall back to word access, so they get the word alignment rule.
  function automatic logic is_misaligned(input logic       mem_write,
                                         input logic [1:0] store_whb,
                                         input logic [2:0] load_whb,
                                         input logic [1:0] offset);
    logic half_acc;
    logic byte_acc;
    if (mem_write) begin
      half_acc = (store_whb == ST_SH);
      byte_acc = (store_whb == ST_SB);
    end else begin
      half_acc = (load_whb == LD_LH) || (load_whb == LD_LHU);
      byte_acc = (load_whb == LD_LB) || (load_whb == LD_LBU);
    end
    if (byte_acc)      return 1'b0;
    else if (half_acc) return offset[0];
    else               return |offset;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the access unit and data memory.
interface mem_access_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_whb,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    result = word;
    case (load_whb)
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'd0, half_sel};
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'd0, byte_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: store lane alignment, load extension and a req/ack
// handshake that stalls the core until the access retires or times out.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        acc_valid,
  input  logic        mem_write,
  input  logic [1:0]  store_whb,
  input  logic [2:0]  load_whb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        align_err,
  output logic        bus_err,
  mem_access_unit_if.master dm
);

  state_t      state;
  state_t      state_next;
  logic [31:0] wait_cnt;
  logic [1:0]  offset_q;
  logic [2:0]  load_whb_q;
  logic        misaligned;
  logic        start;
  logic        ack_hit;
  logic        time_up;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] ext_data;

  assign misaligned = is_misaligned(mem_write, store_whb, load_whb, addr[1:0]);
  assign done       = (state == S_DONE);

  load_extend u_load_extend (
    .word     (dm.dm_rdata),
    .offset   (offset_q),
    .load_whb (load_whb_q),
    .result   (ext_data)
  );

  // Ack is tested before the timeout so an ack on the final allowed cycle still wins.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    start      = 1'b0;
    ack_hit    = 1'b0;
    time_up    = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc_valid && !misaligned) begin
          stall      = 1'b1;
          start      = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dm.dm_ack) begin
          ack_hit    = 1'b1;
          state_next = S_DONE;
        end else if ((TIMEOUT != 0) && (wait_cnt == TIMEOUT - 1)) begin
          time_up    = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    if (mem_write) begin
      case (store_whb)
        ST_SH: begin
          be_next    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{wdata[15:0]}};
        end
        ST_SB: begin
          be_next    = 4'b0001 << addr[1:0];
          wdata_next = {4{wdata[7:0]}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      wait_cnt    <= 32'd0;
      offset_q    <= 2'd0;
      load_whb_q  <= LD_LW;
      rdata       <= 32'd0;
      align_err   <= 1'b0;
      bus_err     <= 1'b0;
      dm.dm_req   <= 1'b0;
      dm.dm_we    <= 1'b0;
      dm.dm_be    <= 4'd0;
      dm.dm_addr  <= 32'd0;
      dm.dm_wdata <= 32'd0;
    end else begin
      state     <= state_next;
      align_err <= (state == S_IDLE) && acc_valid && misaligned;
      bus_err   <= time_up;
      if (start) begin
        dm.dm_req   <= 1'b1;
        dm.dm_we    <= mem_write;
        dm.dm_be    <= be_next;
        dm.dm_addr  <= {addr[31:2], 2'b00};
        dm.dm_wdata <= wdata_next;
        offset_q    <= addr[1:0];
        load_whb_q  <= load_whb;
        wait_cnt    <= 32'd0;
      end else if (state == S_WAIT) begin
        if (ack_hit || time_up) dm.dm_req <= 1'b0;
        else                    wait_cnt  <= wait_cnt + 32'd1;
        if (ack_hit && !dm.dm_we) rdata <= ext_data;
        if (time_up)              rdata <= 32'd0;
      end else if (state == S_DONE) begin
        wait_cnt <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset-abort
// sequence and randomized accesses against a size/offset arithmetic model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TB_TIMEOUT = 4;

  logic        clk;
  logic        rstn;
  logic        acc_valid;
  logic        mem_write;
  logic [1:0]  store_whb;
  logic [2:0]  load_whb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        align_err;
  logic        bus_err;

  int checks;
  int failures;
  logic [31:0] model_rdata;

  mem_access_unit_if dm ();

  mem_access_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .acc_valid (acc_valid),
    .mem_write (mem_write),
    .store_whb (store_whb),
    .load_whb  (load_whb),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .done      (done),
    .align_err (align_err),
    .bus_err   (bus_err),
    .dm        (dm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic [1:0]  swhb;
    logic [2:0]  lwhb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    int          ack_delay;
    logic        exp_align;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_bus;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: access size from the codes, lanes and extension from byte arithmetic.
  function automatic void refModel(input logic mw, input logic [1:0] swhb, input logic [2:0] lwhb,
                                   input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                                   input int delay, input logic [31:0] prev,
                                   output logic al, output logic [3:0] be, output logic [31:0] wdo,
                                   output logic bus, output logic [31:0] rd);
    int size;
    int off;
    longint unsigned mask;
    longint unsigned piece;
    longint unsigned rep;
    logic sgn;
    if (mw) size = (swhb == 2'd1) ? 2 : (swhb == 2'd2) ? 1 : 4;
    else    size = (lwhb == 3'd1 || lwhb == 3'd2) ? 2 : (lwhb == 3'd3 || lwhb == 3'd4) ? 1 : 4;
    sgn  = !mw && (lwhb == 3'd1 || lwhb == 3'd3);
    off  = int'(a[1:0]);
    al   = (off % size) != 0;
    mask = (64'd1 << (8 * size)) - 64'd1;
    be   = mw ? 4'(((1 << size) - 1) << off) : 4'hF;
    rep  = 64'd0;
    for (int k = 0; k < 4 / size; k++) rep |= ({32'd0, wd} & mask) << (8 * size * k);
    wdo   = rep[31:0];
    piece = ({32'd0, word} >> (8 * off)) & mask;
    if (sgn && ((piece >> (8 * size - 1)) & 64'd1) != 0) piece |= ~mask;
    bus = !al && (delay >= TB_TIMEOUT);
    if (al || (mw && !bus)) rd = prev;
    else if (bus)           rd = 32'd0;
    else                    rd = piece[31:0];
  endfunction

  // Runs one access from IDLE through retirement, acking after ack_delay empty WAIT cycles.
  task automatic applyStimulus(input string tag, input logic mw, input logic [1:0] swhb, input logic [2:0] lwhb,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                               input int ack_delay, input logic exp_align, input logic [3:0] exp_be,
                               input logic [31:0] exp_wdata, input logic exp_bus, input logic [31:0] exp_rdata);
    int waits;
    int exp_waits;
    acc_valid = 1'b1;
    mem_write = mw;
    store_whb = swhb;
    load_whb  = lwhb;
    addr      = a;
    wdata     = wd;
    #1;
    checkOutput({tag, "_stall_idle"}, 32'(stall), 32'(!exp_align));
    nextCycle();
    if (exp_align) begin
      checkOutput({tag, "_align_err"}, 32'(align_err), 32'd1);
      checkOutput({tag, "_align_req"}, 32'(dm.dm_req), 32'd0);
      checkOutput({tag, "_align_stall"}, 32'(stall), 32'd0);
      acc_valid = 1'b0;
      nextCycle();
      checkOutput({tag, "_align_pulse"}, 32'(align_err), 32'd0);
      checkOutput({tag, "_align_req2"}, 32'(dm.dm_req), 32'd0);
      checkOutput({tag, "_align_rdata"}, rdata, exp_rdata);
      model_rdata = exp_rdata;
      return;
    end
    acc_valid = 1'b0;
    exp_waits = exp_bus ? TB_TIMEOUT : ack_delay + 1;
    waits = 0;
    while (dm.dm_req === 1'b1 && waits < 20) begin
      checkOutput({tag, "_be"}, 32'(dm.dm_be), 32'(exp_be));
      checkOutput({tag, "_addr"}, dm.dm_addr, {a[31:2], 2'b00});
      checkOutput({tag, "_we"}, 32'(dm.dm_we), 32'(mw));
      if (mw) checkOutput({tag, "_wdata"}, dm.dm_wdata, exp_wdata);
      checkOutput({tag, "_stall_wait"}, 32'(stall), 32'd1);
      dm.dm_ack   = (waits == ack_delay);
      dm.dm_rdata = dm.dm_ack ? word : $urandom;
      nextCycle();
      dm.dm_ack = 1'b0;
      waits++;
    end
    checkOutput({tag, "_wait_cycles"}, 32'(waits), 32'(exp_waits));
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_bus_err"}, 32'(bus_err), 32'(exp_bus));
    checkOutput({tag, "_rdata"}, rdata, exp_rdata);
    checkOutput({tag, "_req_drop"}, 32'(dm.dm_req), 32'd0);
    acc_valid   = 1'($urandom);
    dm.dm_ack   = 1'($urandom);
    dm.dm_rdata = $urandom;
    #1;
    checkOutput({tag, "_stall_done"}, 32'(stall), 32'd0);
    nextCycle();
    acc_valid = 1'b0;
    dm.dm_ack = 1'b0;
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_ignored_req"}, 32'(dm.dm_req), 32'd0);
    checkOutput({tag, "_bus_pulse"}, 32'(bus_err), 32'd0);
    checkOutput({tag, "_rdata_hold"}, rdata, exp_rdata);
    model_rdata = exp_rdata;
  endtask

  initial begin
    logic        al;
    logic [3:0]  be;
    logic [31:0] wdo;
    logic        bus;
    logic [31:0] rd;
    logic        mw;
    logic [1:0]  swhb;
    logic [2:0]  lwhb;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] word;
    int          delay;

    checks      = 0;
    failures    = 0;
    model_rdata = 32'd0;

    //        mw    swhb   lwhb    addr           wdata          word          dly al  be       wdata          bus rdata
    vecs[0]  = '{1'b1, ST_SB, LD_LW,  32'h0000_1003, 32'h1234_5678, 32'h0,        1,  0, 4'b1000, 32'h7878_7878, 0, 32'h0000_0000};
    vecs[1]  = '{1'b0, ST_SW, LD_LB,  32'h0000_0002, 32'h0,         32'h0080_0000, 0, 0, 4'b1111, 32'h0,         0, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, ST_SW, LD_LBU, 32'h0000_0002, 32'h0,         32'h0080_0000, 0, 0, 4'b1111, 32'h0,         0, 32'h0000_0080};
    vecs[3]  = '{1'b0, ST_SW, LD_LH,  32'h0000_0002, 32'h0,         32'h8001_1234, 0, 0, 4'b1111, 32'h0,         0, 32'hFFFF_8001};
    vecs[4]  = '{1'b0, ST_SW, LD_LHU, 32'h0000_0002, 32'h0,         32'h8001_1234, 0, 0, 4'b1111, 32'h0,         0, 32'h0000_8001};
    vecs[5]  = '{1'b1, ST_SH, LD_LW,  32'h0000_0001, 32'hAAAA_BBBB, 32'h0,        0,  1, 4'b0000, 32'h0,         0, 32'h0000_8001};
    vecs[6]  = '{1'b0, ST_SW, LD_LW,  32'h0000_0006, 32'h0,         32'h0,        0,  1, 4'b0000, 32'h0,         0, 32'h0000_8001};
    vecs[7]  = '{1'b0, ST_SW, LD_LW,  32'h0000_0000, 32'h0,         32'h0,        99, 0, 4'b1111, 32'h0,         1, 32'h0000_0000};
    vecs[8]  = '{1'b1, ST_SW, LD_LW,  32'h0000_0020, 32'hDEAD_BEEF, 32'h0,        3,  0, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0000_0000};
    vecs[9]  = '{1'b0, ST_SW, LD_LW,  32'h0000_0024, 32'h0,         32'hCAFE_F00D, 3, 0, 4'b1111, 32'h0,         0, 32'hCAFE_F00D};
    vecs[10] = '{1'b1, ST_SH, LD_LW,  32'h0000_0102, 32'h1234_ABCD, 32'h0,        2,  0, 4'b1100, 32'hABCD_ABCD, 0, 32'hCAFE_F00D};
    vecs[11] = '{1'b1, 2'b11, LD_LW,  32'h0000_0008, 32'h1122_3344, 32'h0,        0,  0, 4'b1111, 32'h1122_3344, 0, 32'hCAFE_F00D};
    vecs[12] = '{1'b0, ST_SW, 3'b111, 32'h0000_000C, 32'h0,         32'h5566_7788, 1, 0, 4'b1111, 32'h0,         0, 32'h5566_7788};
    vecs[13] = '{1'b0, ST_SW, LD_LB,  32'h0000_0001, 32'h0,         32'h0000_7F00, 0, 0, 4'b1111, 32'h0,         0, 32'h0000_007F};

    rstn        = 1'b0;
    acc_valid   = 1'b0;
    mem_write   = 1'b0;
    store_whb   = 2'b00;
    load_whb    = 3'b000;
    addr        = 32'd0;
    wdata       = 32'd0;
    dm.dm_ack   = 1'b0;
    dm.dm_rdata = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_req", 32'(dm.dm_req), 32'd0);
    checkOutput("reset_we", 32'(dm.dm_we), 32'd0);
    checkOutput("reset_be", 32'(dm.dm_be), 32'd0);
    checkOutput("reset_addr", dm.dm_addr, 32'd0);
    checkOutput("reset_wdata", dm.dm_wdata, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_flags", {29'd0, done, align_err, bus_err}, 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    rstn = 1'b1;
    nextCycle();

    for (int i = 0; i < 14; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].mw, vecs[i].swhb, vecs[i].lwhb, vecs[i].addr,
                    vecs[i].wdata, vecs[i].word, vecs[i].ack_delay, vecs[i].exp_align, vecs[i].exp_be,
                    vecs[i].exp_wdata, vecs[i].exp_bus, vecs[i].exp_rdata);
    end

    // Reset while waiting on memory abandons the access.
    acc_valid = 1'b1;
    mem_write = 1'b0;
    load_whb  = LD_LW;
    addr      = 32'h0000_0040;
    nextCycle();
    acc_valid = 1'b0;
    checkOutput("rst_abort_req_up", 32'(dm.dm_req), 32'd1);
    nextCycle();
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_abort_req_drop", 32'(dm.dm_req), 32'd0);
    checkOutput("rst_abort_stall", 32'(stall), 32'd0);
    nextCycle();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput($sformatf("rst_abort_no_done%0d", i), 32'(done), 32'd0);
      checkOutput($sformatf("rst_abort_no_req%0d", i), 32'(dm.dm_req), 32'd0);
    end
    checkOutput("rst_abort_rdata", rdata, 32'd0);
    model_rdata = 32'd0;
    applyStimulus("post_rst_sw", 1'b1, ST_SW, LD_LW, 32'h0000_0010, 32'h0BAD_F00D, 32'h0, 0,
                  1'b0, 4'b1111, 32'h0BAD_F00D, 1'b0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      mw    = 1'($urandom);
      swhb  = 2'($urandom);
      lwhb  = 3'($urandom_range(0, 7));
      a     = $urandom;
      wd    = $urandom;
      word  = $urandom;
      delay = $urandom_range(0, 5);
      refModel(mw, swhb, lwhb, a, wd, word, delay, model_rdata, al, be, wdo, bus, rd);
      applyStimulus($sformatf("rnd%0d", i), mw, swhb, lwhb, a, wd, word, delay, al, be, wdo, bus, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
